// File: rtl/sound_mixer_pkg.sv
// rtl/sound_mixer_pkg.sv - Shared gain code type, gain constants and controller state encoding.
package sound_mixer_pkg;

  typedef logic signed [3:0] gain_code_t;

  localparam gain_code_t GAIN_MUTE  = 4'b1000;
  localparam gain_code_t GAIN_UNITY = 4'b0000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DECIDE
  } gain_ctrl_state_t;

endpackage

// File: rtl/peak_detector.sv
// rtl/peak_detector.sv - Saturating magnitude, running window max and window sample counter.
module peak_detector #(
  parameter int BITS   = 24,
  parameter int WINDOW = 256
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear_i,
  input  logic            accept_i,
  input  logic [BITS-1:0] sample_i,
  output logic [BITS-2:0] peak_o,
  output logic            done_o
);

  localparam int CW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [BITS-1:0] MOST_NEG = {1'b1, {(BITS-1){1'b0}}};

  logic [CW-1:0]   count_q, count_d;
  logic [BITS-2:0] acc_q, acc_d;
  logic [BITS-2:0] mag, max_v;

  always_comb begin
    // The most negative sample has no positive counterpart; clamp it to full scale.
    if (sample_i == MOST_NEG) begin
      mag = '1;
    end else if (sample_i[BITS-1]) begin
      mag = ~sample_i[BITS-2:0] + 1'b1;
    end else begin
      mag = sample_i[BITS-2:0];
    end
    max_v   = (mag > acc_q) ? mag : acc_q;
    done_o  = accept_i && (count_q == CW'(WINDOW - 1));
    peak_o  = max_v;
    acc_d   = acc_q;
    count_d = count_q;
    if (clear_i) begin
      acc_d   = '0;
      count_d = '0;
    end else if (accept_i) begin
      if (done_o) begin
        acc_d   = '0;
        count_d = '0;
      end else begin
        acc_d   = max_v;
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      acc_q   <= '0;
      count_q <= '0;
    end else begin
      acc_q   <= acc_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/gain_level_controller.sv
// rtl/gain_level_controller.sv - AGC top: window FSM, quiet counter and gain register.
// GAIN_CTRL_SOFT_MUTE_EN adds the mute_req port and the ramp down to / back up from GAIN_MUTE.
module gain_level_controller
  import sound_mixer_pkg::*;
#(
  parameter int BITS     = 24,
  parameter int WINDOW   = 256,
  parameter int HOLD     = 4,
  parameter int MIN_GAIN = -7,
  parameter int MAX_GAIN = 7
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            enable,
`ifdef GAIN_CTRL_SOFT_MUTE_EN
  input  logic            mute_req,
`endif
  input  logic            sample_valid,
  input  logic [BITS-1:0] sample_in,
  input  logic [BITS-2:0] target_high,
  input  logic [BITS-2:0] target_low,
  output gain_code_t      gain_out,
  output logic            gain_valid,
  output logic [BITS-2:0] peak_out
);

  localparam int QW = $clog2(HOLD + 1);
  localparam gain_code_t      MIN_CODE = gain_code_t'(MIN_GAIN);
  localparam gain_code_t      MAX_CODE = gain_code_t'(MAX_GAIN);
  localparam logic [QW-1:0]   HOLD_CNT = QW'(HOLD);

  gain_ctrl_state_t state_q, state_d;
  gain_code_t       gain_q, gain_d;
  logic [QW-1:0]    quiet_q, quiet_d, quiet_inc;
  logic             gain_valid_q, gain_valid_d;
  logic [BITS-2:0]  peak_q, peak_d;
  logic [BITS-2:0]  win_peak;
  logic             win_done;
  logic             accept;
  logic             mute;

`ifdef GAIN_CTRL_SOFT_MUTE_EN
  assign mute = mute_req;
`else
  assign mute = 1'b0;
`endif

  // Samples arriving in DECIDE already belong to the next window.
  assign accept = enable && sample_valid && (state_q != IDLE);

  peak_detector #(
    .BITS   (BITS),
    .WINDOW (WINDOW)
  ) u_peak_detector (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear_i  (!enable),
    .accept_i (accept),
    .sample_i (sample_in),
    .peak_o   (win_peak),
    .done_o   (win_done)
  );

  always_comb begin
    state_d      = state_q;
    gain_d       = gain_q;
    quiet_d      = quiet_q;
    peak_d       = peak_q;
    gain_valid_d = 1'b0;
    quiet_inc    = (quiet_q == HOLD_CNT) ? quiet_q : quiet_q + QW'(1);
    if (win_done) begin
      peak_d = win_peak;
    end
    if (!enable) begin
      state_d = IDLE;
      quiet_d = '0;
    end else begin
      case (state_q)
        IDLE:   state_d = ACCUM;
        ACCUM:  if (win_done) state_d = DECIDE;
        DECIDE: begin
          state_d = ACCUM;
          if (mute) begin
            if (gain_q != GAIN_MUTE) gain_d = gain_q - 4'sd1;
            quiet_d = '0;
          end else if (gain_q < MIN_CODE) begin
            gain_d  = gain_q + 4'sd1;
            quiet_d = '0;
          end else if ((peak_q > target_high) && (gain_q > MIN_CODE)) begin
            gain_d  = gain_q - 4'sd1;
            quiet_d = '0;
          end else if (peak_q < target_low) begin
            if ((quiet_inc == HOLD_CNT) && (gain_q < MAX_CODE)) begin
              gain_d  = gain_q + 4'sd1;
              quiet_d = '0;
            end else begin
              quiet_d = quiet_inc;
            end
          end else begin
            quiet_d = '0;
          end
          gain_valid_d = (gain_d != gain_q);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      gain_q       <= GAIN_UNITY;
      quiet_q      <= '0;
      gain_valid_q <= 1'b0;
      peak_q       <= '0;
    end else begin
      state_q      <= state_d;
      gain_q       <= gain_d;
      quiet_q      <= quiet_d;
      gain_valid_q <= gain_valid_d;
      peak_q       <= peak_d;
    end
  end

  assign gain_out   = gain_q;
  assign gain_valid = gain_valid_q;
  assign peak_out   = peak_q;

endmodule

// File: tb/tb_gain_level_controller.sv
// tb/tb_gain_level_controller.sv - Window-level reference model bench for gain_level_controller.
module tb_gain_level_controller;

  localparam int BITS  = 24;
  localparam int WIN   = 4;
  localparam int HOLD  = 2;
  localparam int MIN_G = -7;
  localparam int MAX_G = 7;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        sample_valid;
  logic        mute_req;
  logic [23:0] sample_in;
  logic [22:0] target_high;
  logic [22:0] target_low;
  logic [22:0] peak_out;
  logic [3:0]  gain_out;
  logic        gain_valid;

  int errors = 0;
  int checks = 0;
  int mgain, mquiet, mpeak;

  always #5 clock = ~clock;

  gain_level_controller #(
    .BITS     (BITS),
    .WINDOW   (WIN),
    .HOLD     (HOLD),
    .MIN_GAIN (MIN_G),
    .MAX_GAIN (MAX_G)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
`ifdef GAIN_CTRL_SOFT_MUTE_EN
    .mute_req     (mute_req),
`endif
    .sample_valid (sample_valid),
    .sample_in    (sample_in),
    .target_high  (target_high),
    .target_low   (target_low),
    .gain_out     (gain_out),
    .gain_valid   (gain_valid),
    .peak_out     (peak_out)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int mag_of(logic [23:0] x);
    int s;
    s = int'($signed(x));
    if (s == -(1 << 23)) return (1 << 23) - 1;
    return (s < 0) ? -s : s;
  endfunction

  function automatic logic [23:0] rand_sample(int cap);
    int m;
    m = int'($urandom_range(0, cap));
    if ($urandom_range(0, 7) == 0) return 24'h800000;
    if ($urandom_range(0, 1) == 1) return 24'(-m);
    return 24'(m);
  endfunction

  task automatic model_decide(int peak);
    if (mute_req) begin
      if (mgain > -8) mgain--;
      mquiet = 0;
    end else if (mgain < MIN_G) begin
      mgain++;
      mquiet = 0;
    end else if (peak > int'(target_high) && mgain > MIN_G) begin
      mgain--;
      mquiet = 0;
    end else if (peak < int'(target_low)) begin
      mquiet = (mquiet + 1 > HOLD) ? HOLD : mquiet + 1;
      if (mquiet == HOLD && mgain < MAX_G) begin
        mgain++;
        mquiet = 0;
      end
    end else begin
      mquiet = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    sample_valid = 1'b0;
    enable = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    mgain = 0;
    mquiet = 0;
    mpeak = 0;
    tick();
  endtask

  task automatic run_window(input logic [23:0] a, b, c, d, input bit gaps);
    logic [23:0] s[4];
    int pk, old_gain, old_peak;
    s = '{a, b, c, d};
    old_gain = mgain;
    old_peak = mpeak;
    pk = 0;
    for (int i = 0; i < 4; i++) begin
      if (mag_of(s[i]) > pk) pk = mag_of(s[i]);
      sample_in = s[i];
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      if (i == 2) begin
        checks++;
        if (peak_out !== 23'(old_peak)) begin
          errors++;
          $display("FAIL early_peak: peak_out=%h required=%h", peak_out, 23'(old_peak));
        end
      end
      if (i < 3 && gaps) begin
        repeat ($urandom_range(0, 2)) begin
          sample_in = 24'($urandom());
          tick();
        end
      end
    end
    mpeak = pk;
    checks++;
    if (peak_out !== 23'(pk)) begin
      errors++;
      $display("FAIL window_peak: peak_out=%h required=%h", peak_out, 23'(pk));
    end
    checks++;
    if (gain_out !== 4'(old_gain) || gain_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_decide: gain_out=%b gain_valid=%b required=%b/0", gain_out, gain_valid, 4'(old_gain));
    end
    model_decide(pk);
    tick();
    checks++;
    if (gain_out !== 4'(mgain)) begin
      errors++;
      $display("FAIL decide_gain: gain_out=%b required=%b", gain_out, 4'(mgain));
    end
    checks++;
    if (gain_valid !== (mgain != old_gain)) begin
      errors++;
      $display("FAIL decide_valid: gain_valid=%b required=%b", gain_valid, (mgain != old_gain));
    end
    tick();
    checks++;
    if (gain_valid !== 1'b0) begin
      errors++;
      $display("FAIL valid_pulse: gain_valid=%b required=0", gain_valid);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    enable = 1'b0;
    sample_valid = 1'b0;
    mute_req = 1'b0;
    sample_in = '0;
    target_high = 23'h600000;
    target_low = 23'h100000;
    tick();
    tick();
    checks++;
    if (gain_out !== 4'b0000 || gain_valid !== 1'b0 || peak_out !== 23'h0) begin
      errors++;
      $display("FAIL reset_state: gain=%b valid=%b peak=%h required 0000/0/000000", gain_out, gain_valid, peak_out);
    end
    do_reset();
  endtask

  task automatic test_attack();
    run_window(24'h700000, 24'h700000, 24'h700000, 24'h700000, 1'b0);
    checks++;
    if (gain_out !== 4'b1111 || peak_out !== 23'h700000) begin
      errors++;
      $display("FAIL attack: gain=%b peak=%h required 1111/700000", gain_out, peak_out);
    end
  endtask

  task automatic test_saturation();
    run_window(24'h000100, 24'h810000, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (peak_out !== 23'h7F0000) begin
      errors++;
      $display("FAIL neg_magnitude: peak=%h required 7F0000", peak_out);
    end
    run_window(24'h800000, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (peak_out !== 23'h7FFFFF) begin
      errors++;
      $display("FAIL most_negative: peak=%h required 7FFFFF", peak_out);
    end
  endtask

  task automatic test_reset_mid_window();
    for (int i = 0; i < 2; i++) begin
      sample_in = 24'h700000;
      sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    reset_n = 1'b0;
    tick();
    checks++;
    if (gain_out !== 4'b0000 || gain_valid !== 1'b0 || peak_out !== 23'h0) begin
      errors++;
      $display("FAIL reset_mid_window: gain=%b valid=%b peak=%h required 0000/0/000000", gain_out, gain_valid, peak_out);
    end
    reset_n = 1'b1;
    mgain = 0;
    mquiet = 0;
    mpeak = 0;
    tick();
    run_window(24'h700000, 24'h700000, 24'h700000, 24'h700000, 1'b0);
  endtask

  task automatic test_release();
    do_reset();
    run_window(24'h000100, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b0000) begin
      errors++;
      $display("FAIL release_hold: gain=%b required 0000", gain_out);
    end
    run_window(24'h000100, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b0001) begin
      errors++;
      $display("FAIL release_step: gain=%b required 0001", gain_out);
    end
    for (int k = 0; k < 20 && mgain < MAX_G; k++)
      run_window(24'h000100, 24'hFFFF00, 24'h000100, 24'h000100, 1'b0);
    for (int k = 0; k < 3; k++)
      run_window(24'h000100, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b0111) begin
      errors++;
      $display("FAIL max_clamp: gain=%b required 0111", gain_out);
    end
  endtask

  task automatic test_min_clamp();
    for (int k = 0; k < 16; k++)
      run_window(24'h7FFFFF, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b1001) begin
      errors++;
      $display("FAIL min_clamp: gain=%b required 1001", gain_out);
    end
  endtask

  task automatic test_enable();
    for (int i = 0; i < 2; i++) begin
      sample_in = 24'h7FFFFF;
      sample_valid = 1'b1;
      tick();
    end
    enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample_in = 24'h7FFFFF;
      sample_valid = 1'b1;
      tick();
      checks++;
      if (gain_out !== 4'(mgain) || gain_valid !== 1'b0 || peak_out !== 23'(mpeak)) begin
        errors++;
        $display("FAIL disabled_hold: gain=%b valid=%b peak=%h required %b/0/%h", gain_out, gain_valid, peak_out, 4'(mgain), 23'(mpeak));
      end
    end
    mquiet = 0;
    sample_valid = 1'b0;
    enable = 1'b1;
    tick();
    run_window(24'h000100, 24'h000200, 24'h0F0000, 24'h000100, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [23:0] s[8];
    int old_gain;
    s = '{24'h050000, 24'h050000, 24'h050000, 24'h050000,
          24'h7A0000, 24'h000100, 24'h000100, 24'h000100};
    for (int i = 0; i < 8; i++) begin
      sample_in = s[i];
      sample_valid = 1'b1;
      tick();
      if (i == 3 || i == 7) begin
        mpeak = (i == 3) ? 32'h050000 : 32'h7A0000;
        checks++;
        if (peak_out !== 23'(mpeak)) begin
          errors++;
          $display("FAIL b2b_peak%0d: peak=%h required %h", i, peak_out, 23'(mpeak));
        end
        model_decide(mpeak);
      end
      if (i == 4) begin
        checks++;
        if (gain_out !== 4'(mgain)) begin
          errors++;
          $display("FAIL b2b_gain1: gain=%b required %b", gain_out, 4'(mgain));
        end
      end
    end
    sample_valid = 1'b0;
    old_gain = int'($signed(gain_out));
    tick();
    checks++;
    if (gain_out !== 4'(mgain) || gain_valid !== (mgain != old_gain)) begin
      errors++;
      $display("FAIL b2b_gain2: gain=%b valid=%b required %b/%b", gain_out, gain_valid, 4'(mgain), (mgain != old_gain));
    end
    tick();
  endtask

  task automatic test_random();
    int cap;
    for (int w = 0; w < 40; w++) begin
      case ($urandom_range(0, 3))
        0: cap = 32'h0FFFFF;
        1: cap = 32'h0FFFFF;
        2: cap = 32'h5FFFFF;
        default: cap = 32'h7FFFFF;
      endcase
`ifdef GAIN_CTRL_SOFT_MUTE_EN
      mute_req = ($urandom_range(0, 5) == 0);
`endif
      run_window(rand_sample(cap), rand_sample(cap), rand_sample(cap), rand_sample(cap), 1'b1);
    end
    mute_req = 1'b0;
  endtask

`ifdef GAIN_CTRL_SOFT_MUTE_EN
  task automatic test_soft_mute();
    do_reset();
    mute_req = 1'b1;
    for (int k = 0; k < 9; k++)
      run_window(24'h7FFFFF, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b1000) begin
      errors++;
      $display("FAIL mute_floor: gain=%b required 1000", gain_out);
    end
    mute_req = 1'b0;
    run_window(24'h000100, 24'h000100, 24'h000100, 24'h000100, 1'b0);
    checks++;
    if (gain_out !== 4'b1001) begin
      errors++;
      $display("FAIL mute_release: gain=%b required 1001", gain_out);
    end
    for (int k = 0; k < 3; k++)
      run_window(24'h000100, 24'h000100, 24'h000100, 24'h000100, 1'b0);
  endtask
`endif

  initial begin
    test_reset();
    test_attack();
    test_saturation();
    test_reset_mid_window();
    test_release();
    test_min_clamp();
    test_enable();
    test_back_to_back();
    test_random();
`ifdef GAIN_CTRL_SOFT_MUTE_EN
    test_soft_mute();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
